// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer and the 9-bit proc core:
// sequencer state encoding and the instruction opcode field.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DATA  = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

    // Extract the opcode field from a 9-bit instruction word.
    function automatic logic [2:0] opcodeOf(input logic [8:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Bundle of the sequencer's ROM bus, proc handshake and status signals.
// master = the sequencer, slave = the ROM / proc / control side.
interface prog_sequencer_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Done;
    logic [8:0]       mem_q;
    logic [AW-1:0]    mem_addr;
    logic [8:0]       DIN;
    logic             Run;
    logic             Busy;
    logic             Halted;
    logic [AW-1:0]    pc;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  Start, Done, mem_q,
        output mem_addr, DIN, Run, Busy, Halted, pc, instr_count
    );

    modport slave (
        output Start, Done, mem_q,
        input  mem_addr, DIN, Run, Busy, Halted, pc, instr_count
    );
endinterface

// File: rtl/seq_pc.sv
// Program counter: AW-bit register with load-zero and increment.
// pc_next_o is exposed so the ROM can be addressed one cycle early,
// hiding the ROM's registered read latency.
module seq_pc #(
    parameter int AW = 5
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          loadZero_i,
    input  logic          incr_i,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc_next_o
);
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    // Next pc: load-zero wins over increment; increment wraps modulo 2**AW.
    always_comb begin
        pc_d = pc_q;
        if (loadZero_i) begin
            pc_d = '0;
        end else if (incr_i) begin
            pc_d = pc_q + AW'(1);
        end
    end

    // pc register with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/prog_sequencer.sv
// Instruction feeder for the 9-bit proc core. Fetches words from a
// synchronous ROM, issues them with Run, supplies the mvi immediate,
// waits for Done, counts retired instructions and stops on a HALT word.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic                Clock,
    input  logic                Resetn,
    prog_sequencer_if.master    bus
);
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             runNext;
    logic             loadZero;
    logic             incrPc;
    logic             countInc;
    logic             countClr;
    logic [2:0]       opcode;
    logic [AW-1:0]    pcNow;
    logic [AW-1:0]    pcNext;

    assign opcode = opcodeOf(bus.mem_q);

    seq_pc #(.AW(AW)) u_pc (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .loadZero_i (loadZero),
        .incr_i     (incrPc),
        .pc_o       (pcNow),
        .pc_next_o  (pcNext)
    );

    // Next-state and control decode; the ROM word on mem_q is always mem[pc].
    always_comb begin
        state_d  = state_q;
        runNext  = 1'b0;
        loadZero = 1'b0;
        incrPc   = 1'b0;
        countInc = 1'b0;
        countClr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    loadZero = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    runNext = 1'b1;
                    incrPc  = 1'b1;
                    state_d = (opcode == OP_MVI) ? DATA : WAIT;
                end
            end
            DATA: begin
                incrPc = 1'b1;
                if (bus.Done) begin
                    countInc = 1'b1;
                    state_d  = ISSUE;
                end else begin
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.Done) begin
                    countInc = 1'b1;
                    state_d  = ISSUE;
                end
            end
            HALT: begin
                if (bus.Start) begin
                    loadZero = 1'b1;
                    countClr = 1'b1;
                    state_d  = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Retired-instruction counter next value; wraps modulo 2**CNT_W.
    always_comb begin
        count_d = count_q;
        if (countClr) begin
            count_d = '0;
        end else if (countInc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State and counter registers; reset returns to IDLE at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.mem_addr    = pcNext;
    assign bus.DIN         = bus.mem_q;
    assign bus.Run         = runNext;
    assign bus.Busy        = (state_q == ISSUE) || (state_q == DATA) || (state_q == WAIT);
    assign bus.Halted      = (state_q == HALT);
    assign bus.pc          = pcNow;
    assign bus.instr_count = count_q;

endmodule
